// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory (sync write, combinational read)
// between instruction fetch (port 0) and data load/store (port 1).
// One transaction = IDLE (arbitrate) -> ACCESS (drive memory) -> DONE (ack).
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   req/we/a/wd 0,1   requester inputs, held stable until the matching ack
//   ack0, ack1        one-cycle completion pulses
//   rdata             word read during ACCESS, valid in the ack cycle
//   busy              sequencer not in IDLE
//   mem_we/a/wd       drive the memory; mem_rd is its combinational read data
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] a0,
    input  logic [DATA_W-1:0] wd0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] a1,
    input  logic [DATA_W-1:0] wd1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              win, win_nxt;
    logic              last_grant, last_grant_nxt;
    logic              ack0_nxt, ack1_nxt;
    logic              busy_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_a_nxt;
    logic [DATA_W-1:0] mem_wd_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic              pick1_c;

    // Port 1 wins alone, or on a tie under fixed priority, or when port 0 was served last.
    assign pick1_c = req1 & (~req0 | (FIXED_PRIO != 0) | ~last_grant);

    // Next-state and next-output logic; mem_we is only ever set on entry to ACCESS.
    always_comb begin
        state_nxt      = state;
        win_nxt        = win;
        last_grant_nxt = last_grant;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        mem_we_nxt     = 1'b0;
        mem_a_nxt      = mem_a;
        mem_wd_nxt     = mem_wd;
        rdata_nxt      = rdata;

        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_nxt  = ACCESS;
                    win_nxt    = pick1_c;
                    mem_we_nxt = pick1_c ? we1 : we0;
                    mem_a_nxt  = pick1_c ? a1  : a0;
                    mem_wd_nxt = pick1_c ? wd1 : wd0;
                end
            end
            ACCESS: begin
                state_nxt      = DONE;
                rdata_nxt      = mem_rd;
                last_grant_nxt = win;
                ack0_nxt       = ~win;
                ack1_nxt       = win;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs; last_grant resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            win        <= 1'b0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_nxt;
            win        <= win_nxt;
            last_grant <= last_grant_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            busy       <= busy_nxt;
            mem_we     <= mem_we_nxt;
            mem_a      <= mem_a_nxt;
            mem_wd     <= mem_wd_nxt;
            rdata      <= rdata_nxt;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified memory (sync write, combinational read; ports clk/we/a/wd/rd) of the multicycle core between two requesters.
- Port 0 is instruction fetch; port 1 is data load/store.
- Implemented as a 3-state sequencer. It registers the winning request, drives the memory for exactly one cycle, then returns the read word with a one-cycle ack pulse.
- Sits between the multicycle controller/datapath and the memory instance.

Parameters:
- ADDR_W, 32, address width passed through to memory.
- DATA_W, 32, data word width.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 1 (data) always wins ties.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  fetch request; held until ack0.
- we0  in  1  fetch write enable; normally 0, honoured if 1.
- a0  in  ADDR_W  fetch address.
- wd0  in  DATA_W  fetch write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- req1, we1, a1, wd1, ack1: same as port 0, for port 1.
- rdata  out  DATA_W  read word, valid in the ack cycle.
- busy  out  1  high when state is not IDLE.
- mem_we  out  1  to memory we.
- mem_a  out  ADDR_W  to memory a.
- mem_wd  out  DATA_W  to memory wd.
- mem_rd  in  DATA_W  from memory rd.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ack0=ack1=0; mem_we=0; mem_a=0; mem_wd=0; rdata=0; busy=0; last-grant=1, so port 0 wins the first tie.
- State IDLE, no request: remain in IDLE.
- State IDLE, any req sampled high at the clock edge:
  - Pick the winner.
  - Latch winner id, we, a and wd into internal registers.
  - Go to ACCESS.
- Winner selection:
  - Single requester wins.
  - On a tie with FIXED_PRIO=0, the port not granted last wins.
  - On a tie with FIXED_PRIO=1, port 1 wins.
- State ACCESS (exactly 1 cycle):
  - mem_a and mem_wd show the latched values; mem_we equals the latched we.
  - At the closing edge, memory performs any write and rdata captures mem_rd.
  - Update last-grant; go to DONE.
- State DONE (exactly 1 cycle):
  - ack of the winner = 1; the other ack = 0; mem_we = 0.
  - Go to IDLE.
- mem_we is 0 in every state except ACCESS.
- mem_a and mem_wd hold the last latched values outside ACCESS.
- rdata holds its value until the next ACCESS. For writes, rdata = the old memory word at that address (combinational read before the write edge).
- Latency: req high at edge E, then ACCESS in cycle E+1, then ack in cycle E+2. Minimum 3 cycles per transaction including the IDLE cycle.
- Requester rules:
  - Hold req, we, a and wd stable from assertion through the ack cycle.
  - Deassert req at the edge ending the ack cycle.
  - A req still high at the IDLE-cycle edge after DONE is a new request.
- The losing requester keeps req high. It is served in the next arbitration, since the winner has dropped or is rotated away.
- Inputs sampled outside IDLE are ignored; no queueing.
- Reset mid-transaction: immediately IDLE, mem_we=0, no ack issued. A write in ACCESS is aborted if reset lands before the edge.
- Both ack outputs are never high in the same cycle. Each ack is never high for more than 1 consecutive cycle.

Test Plan:
- Reset, then req0=1, a0=10, while mem[10]=0x00000010 → ACCESS with mem_a=10 and mem_we=0; 2 cycles after sampling, ack0=1 for 1 cycle and rdata=0x00000010.
- req1=1, we1=1, a1=25, wd1=0xabcd1234 → mem_we=1 for exactly 1 cycle with mem_a=25 and mem_wd=0xabcd1234; ack1 pulses. A following port-1 read of address 25 returns 0xabcd1234.
- FIXED_PRIO=0, req0 and req1 both held high continuously, reading a0=5 and a1=25 → acks alternate ack0, ack1, ack0, ack1 (first is ack0), one ack every 3 cycles, each rdata matching its address.
- FIXED_PRIO=1, simultaneous req0 and req1 → ack1 first. ack0 follows in the next transaction only after req1 drops.
- Assert reset low during ACCESS of a write to address 25 (old value 0x11111111) → mem_we falls to 0 immediately, no ack, busy=0; a subsequent read of address 25 returns 0x11111111.
- No requests for 20 cycles → busy=0, mem_we=0, both acks 0 throughout.
